// File: rtl/hist2d_bin_accum.sv
// hist2d_bin_accum
// Per-bin hit counter for the 2D I/Q histogram. Each in-range hit does a
// read-modify-write of its bin counter in a simple-dual-port RAM. Repeated
// bins are forwarded so no increment is lost. The block also provides a
// full-histogram clear sweep and a random-access readout port that shares
// the RAM read port with the hit pipeline.
`timescale 1ns/1ps

module hist2d_bin_accum #(
    parameter int COORD_W = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk100,
    input  logic               system_reset,
    input  logic               i_q_found,
    input  logic [COORD_W-1:0] i_bin_coord,
    input  logic [COORD_W-1:0] q_bin_coord,
    input  logic [COORD_W-1:0] i_bin_num,
    input  logic [COORD_W-1:0] q_bin_num,
    input  logic               clear_start,
    output logic               busy,
    input  logic               rd_req,
    input  logic [COORD_W-1:0] rd_i,
    input  logic [COORD_W-1:0] rd_q,
    output logic               rd_ready,
    output logic               rd_valid,
    output logic [COUNT_W-1:0] rd_count,
    output logic [31:0]        hit_total,
    output logic [15:0]        drop_total
);

    localparam int ADDR_W = 2 * COORD_W;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [ADDR_W-1:0]  ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0]  ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0]  ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0] COUNT_ZERO = {COUNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // Saturating counter increment used by the read-modify-write stage.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        if (v == COUNT_MAX) begin
            sat_inc = COUNT_MAX;
        end else begin
            sat_inc = v + COUNT_ONE;
        end
    endfunction

    // Control state
    state_t             state_r;
    state_t             state_nxt_s;
    logic [ADDR_W-1:0]  clr_addr_r;
    logic               rd_en_r;
    logic               busy_r;

    // Stage 0 decode
    logic               is_idle_s;
    logic               in_range_s;
    logic               hit_acc_s;
    logic               hit_drop_s;
    logic               rd_ready_s;
    logic               rd_acc_s;
    logic [ADDR_W-1:0]  s0_addr_s;

    // Pipeline registers
    logic               s1_hit_r;
    logic               s1_rd_r;
    logic [ADDR_W-1:0]  s1_addr_r;
    logic               s2_hit_r;
    logic [ADDR_W-1:0]  s2_addr_r;
    logic [COUNT_W-1:0] s2_data_r;
    logic               s3_vld_r;
    logic [ADDR_W-1:0]  s3_addr_r;
    logic [COUNT_W-1:0] s3_data_r;
    logic [COUNT_W-1:0] s1_data_s;
    logic [COUNT_W-1:0] s2_wval_s;

    // RAM ports
    logic [COUNT_W-1:0] mem_r [DEPTH];
    logic [COUNT_W-1:0] ram_rdata_r;
    logic               ram_we_s;
    logic [ADDR_W-1:0]  ram_waddr_s;
    logic [COUNT_W-1:0] ram_wdata_s;

    // Output registers
    logic               rd_valid_r;
    logic [COUNT_W-1:0] rd_count_r;
    logic [31:0]        hit_total_r;
    logic [15:0]        drop_total_r;

    assign is_idle_s  = (state_r == ST_IDLE);
    assign in_range_s = (i_bin_coord < i_bin_num) && (q_bin_coord < q_bin_num);
    assign hit_acc_s  = i_q_found & is_idle_s & in_range_s;
    assign hit_drop_s = i_q_found & ~(is_idle_s & in_range_s);
    // A hit strobe always wins the read port, so any strobe stalls the reader.
    assign rd_ready_s = rd_en_r & is_idle_s & ~i_q_found;
    assign rd_acc_s   = rd_req & rd_ready_s;
    assign s0_addr_s  = hit_acc_s ? {i_bin_coord, q_bin_coord} : {rd_i, rd_q};
    assign s2_wval_s  = sat_inc(s2_data_r);

    // Next-state logic: clear waits for in-flight hits before sweeping.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (clear_start) begin
                    // S2 must be empty on the first sweep cycle, since both
                    // use the single write port.
                    if (!hit_acc_s && !s1_hit_r) begin
                        state_nxt_s = ST_CLEAR;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!s1_hit_r) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_CLEAR: begin
                if (clr_addr_r == ADDR_LAST) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register, sweep address, busy flag and readout enable.
    always_ff @(posedge clk100 or posedge system_reset) begin
        if (system_reset) begin
            state_r    <= ST_IDLE;
            clr_addr_r <= ADDR_ZERO;
            busy_r     <= 1'b0;
            rd_en_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
            rd_en_r    <= 1'b1;
            if (state_r == ST_CLEAR) begin
                clr_addr_r <= clr_addr_r + ADDR_ONE;
            end else begin
                clr_addr_r <= ADDR_ZERO;
            end
        end
    end

    // Stage-1 data select: newest pending write to the same bin wins over RAM.
    always_comb begin
        s1_data_s = ram_rdata_r;
        if (s2_hit_r && (s2_addr_r == s1_addr_r)) begin
            s1_data_s = s2_wval_s;
        end else if (s3_vld_r && (s3_addr_r == s1_addr_r)) begin
            // Write committed on the same edge the RAM was read, so the RAM
            // output still holds the old value.
            s1_data_s = s3_data_r;
        end else begin
            s1_data_s = ram_rdata_r;
        end
    end

    // Write-port mux: sweep zeroes during CLEAR, otherwise the S2 update.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = ADDR_ZERO;
        ram_wdata_s = COUNT_ZERO;
        if (state_r == ST_CLEAR) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = clr_addr_r;
            ram_wdata_s = COUNT_ZERO;
        end else begin
            ram_we_s    = s2_hit_r;
            ram_waddr_s = s2_addr_r;
            ram_wdata_s = s2_wval_s;
        end
    end

    // Counter RAM write port (contents intentionally not reset).
    always_ff @(posedge clk100) begin
        if (ram_we_s) begin
            mem_r[ram_waddr_s] <= ram_wdata_s;
        end
    end

    // Counter RAM read port, one-cycle latency.
    always_ff @(posedge clk100) begin
        ram_rdata_r <= mem_r[s0_addr_s];
    end

    // Hit/readout pipeline stages S1..S3.
    always_ff @(posedge clk100 or posedge system_reset) begin
        if (system_reset) begin
            s1_hit_r  <= 1'b0;
            s1_rd_r   <= 1'b0;
            s1_addr_r <= ADDR_ZERO;
            s2_hit_r  <= 1'b0;
            s2_addr_r <= ADDR_ZERO;
            s2_data_r <= COUNT_ZERO;
            s3_vld_r  <= 1'b0;
            s3_addr_r <= ADDR_ZERO;
            s3_data_r <= COUNT_ZERO;
        end else begin
            s1_hit_r  <= hit_acc_s;
            s1_rd_r   <= rd_acc_s;
            s1_addr_r <= s0_addr_s;
            s2_hit_r  <= s1_hit_r;
            s2_addr_r <= s1_addr_r;
            s2_data_r <= s1_data_s;
            s3_vld_r  <= s2_hit_r;
            s3_addr_r <= s2_addr_r;
            s3_data_r <= s2_wval_s;
        end
    end

    // Readout result register: pulses valid two cycles after accept.
    always_ff @(posedge clk100 or posedge system_reset) begin
        if (system_reset) begin
            rd_valid_r <= 1'b0;
            rd_count_r <= COUNT_ZERO;
        end else begin
            rd_valid_r <= s1_rd_r;
            if (s1_rd_r) begin
                rd_count_r <= s1_data_s;
            end else begin
                rd_count_r <= rd_count_r;
            end
        end
    end

    // Hit and drop statistics; hit_total restarts when a sweep begins.
    always_ff @(posedge clk100 or posedge system_reset) begin
        if (system_reset) begin
            hit_total_r  <= 32'd0;
            drop_total_r <= 16'd0;
        end else begin
            if ((state_nxt_s == ST_CLEAR) && (state_r != ST_CLEAR)) begin
                hit_total_r <= 32'd0;
            end else if (hit_acc_s) begin
                hit_total_r <= hit_total_r + 32'd1;
            end else begin
                hit_total_r <= hit_total_r;
            end
            if (hit_drop_s && (drop_total_r != 16'hFFFF)) begin
                drop_total_r <= drop_total_r + 16'd1;
            end else begin
                drop_total_r <= drop_total_r;
            end
        end
    end

    assign busy       = busy_r;
    assign rd_ready   = rd_ready_s;
    assign rd_valid   = rd_valid_r;
    assign rd_count   = rd_count_r;
    assign hit_total  = hit_total_r;
    assign drop_total = drop_total_r;

endmodule
